// File: rtl/regbank_wb_sched.sv
// Write-back scheduler and busy scoreboard for the 32x32 register bank: round-robin ALU/LD/MUL arbitration.
// Optional WB_FORWARD_EN adds forwarding of the write currently presented to the bank.
module regbank_wb_sched #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int NREG       = 32,
  parameter int MUL_HI_REG = 19,
  parameter int MUL_LO_REG = 20
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          alu_req_i,
  input  logic [AW-1:0] alu_rd_i,
  input  logic [DW-1:0] alu_data_i,
  output logic          alu_gnt_o,
  input  logic          ld_req_i,
  input  logic [AW-1:0] ld_rd_i,
  input  logic [DW-1:0] ld_data_i,
  output logic          ld_gnt_o,
  input  logic          mul_req_i,
  input  logic [DW-1:0] mul_hi_i,
  input  logic [DW-1:0] mul_lo_i,
  output logic          mul_gnt_o,
  input  logic          iss_valid_i,
  input  logic [AW-1:0] iss_rd_i,
  input  logic          iss_double_i,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  output logic          hazard_o,
  output logic          write_en_o,
  output logic [AW-1:0] reg_wr_o,
  output logic [DW-1:0] data_o,
  output logic [DW-1:0] mult_high_o,
  output logic [DW-1:0] mult_low_o,
`ifdef WB_FORWARD_EN
  output logic          fwd1_valid_o,
  output logic [DW-1:0] fwd1_data_o,
  output logic          fwd2_valid_o,
  output logic [DW-1:0] fwd2_data_o,
`endif
  output logic          double_o
);

  localparam logic [AW-1:0] HI_ADDR = AW'(MUL_HI_REG);
  localparam logic [AW-1:0] LO_ADDR = AW'(MUL_LO_REG);

  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_LD = 2'd1, SRC_MUL = 2'd2} src_e;

  src_e            ptr_q, ptr_d;
  logic            alu_win, ld_win, mul_win;
  logic            wen_q, wen_d, dbl_q, dbl_d;
  logic [AW-1:0]   reg_wr_q, reg_wr_d;
  logic [DW-1:0]   data_q, data_d, mh_q, mh_d, ml_q, ml_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            busy1, busy2, hit1, hit2;

  always_comb begin
    alu_win = 1'b0;
    ld_win  = 1'b0;
    mul_win = 1'b0;
    case (ptr_q)
      SRC_LD: begin
        if (ld_req_i) ld_win = 1'b1;
        else if (mul_req_i) mul_win = 1'b1;
        else if (alu_req_i) alu_win = 1'b1;
        else alu_win = 1'b0;
      end
      SRC_MUL: begin
        if (mul_req_i) mul_win = 1'b1;
        else if (alu_req_i) alu_win = 1'b1;
        else if (ld_req_i) ld_win = 1'b1;
        else alu_win = 1'b0;
      end
      default: begin
        if (alu_req_i) alu_win = 1'b1;
        else if (ld_req_i) ld_win = 1'b1;
        else if (mul_req_i) mul_win = 1'b1;
        else alu_win = 1'b0;
      end
    endcase
    if (alu_win) ptr_d = SRC_LD;
    else if (ld_win) ptr_d = SRC_MUL;
    else if (mul_win) ptr_d = SRC_ALU;
    else ptr_d = ptr_q;
  end

  // Grants are suppressed while reset is asserted so no source believes it was consumed.
  assign alu_gnt_o = alu_win & rst_ni;
  assign ld_gnt_o  = ld_win & rst_ni;
  assign mul_gnt_o = mul_win & rst_ni;

  always_comb begin
    wen_d    = 1'b0;
    dbl_d    = 1'b0;
    reg_wr_d = reg_wr_q;
    data_d   = data_q;
    mh_d     = mh_q;
    ml_d     = ml_q;
    busy_d   = busy_q;
    if (alu_win) begin
      wen_d            = (alu_rd_i != '0);
      reg_wr_d         = alu_rd_i;
      data_d           = alu_data_i;
      busy_d[alu_rd_i] = 1'b0;
    end else if (ld_win) begin
      wen_d           = (ld_rd_i != '0);
      reg_wr_d        = ld_rd_i;
      data_d          = ld_data_i;
      busy_d[ld_rd_i] = 1'b0;
    end else if (mul_win) begin
      wen_d           = 1'b1;
      dbl_d           = 1'b1;
      reg_wr_d        = HI_ADDR;
      mh_d            = mul_hi_i;
      ml_d            = mul_lo_i;
      busy_d[HI_ADDR] = 1'b0;
      busy_d[LO_ADDR] = 1'b0;
    end else begin
      wen_d = 1'b0;
    end
    // Issue is applied after the clear so a newer producer keeps the register busy.
    if (iss_valid_i) begin
      if (iss_double_i) begin
        busy_d[HI_ADDR] = 1'b1;
        busy_d[LO_ADDR] = 1'b1;
      end else begin
        busy_d[iss_rd_i] = 1'b1;
      end
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= SRC_ALU;
      wen_q    <= 1'b0;
      dbl_q    <= 1'b0;
      reg_wr_q <= '0;
      data_q   <= '0;
      mh_q     <= '0;
      ml_q     <= '0;
      busy_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wen_q    <= wen_d;
      dbl_q    <= dbl_d;
      reg_wr_q <= reg_wr_d;
      data_q   <= data_d;
      mh_q     <= mh_d;
      ml_q     <= ml_d;
      busy_q   <= busy_d;
    end
  end

  assign write_en_o  = wen_q;
  assign double_o    = dbl_q;
  assign reg_wr_o    = reg_wr_q;
  assign data_o      = data_q;
  assign mult_high_o = mh_q;
  assign mult_low_o  = ml_q;

  assign busy1 = (rs1_i != '0) & busy_q[rs1_i];
  assign busy2 = (rs2_i != '0) & busy_q[rs2_i];
  // A double write occupies both the high register (reg_wr) and the low register.
  assign hit1  = wen_q & (rs1_i != '0) & ((rs1_i == reg_wr_q) | (dbl_q & (rs1_i == LO_ADDR)));
  assign hit2  = wen_q & (rs2_i != '0) & ((rs2_i == reg_wr_q) | (dbl_q & (rs2_i == LO_ADDR)));

`ifdef WB_FORWARD_EN
  assign hazard_o     = busy1 | busy2;
  assign fwd1_valid_o = hit1;
  assign fwd2_valid_o = hit2;
  assign fwd1_data_o  = dbl_q ? ((rs1_i == LO_ADDR) ? ml_q : mh_q) : data_q;
  assign fwd2_data_o  = dbl_q ? ((rs2_i == LO_ADDR) ? ml_q : mh_q) : data_q;
`else
  assign hazard_o = busy1 | busy2 | hit1 | hit2;
`endif

endmodule
